gwa_ausgabe: RTL and testbench

Payout/dispense controller at the output side of the drink vending machine. Accepts the single-cycle dispense and coin-return commands issued by the vending-machine control FSM: 1 € drink, 2 € drink, 1 € return and 2 € return. It queues them per type and serves them one at a time. Each command drives the matching actuator for a fixed pulse, waits for the mechanism's completion sensor, then observes a cool-down gap.

---
 rtl/gwa_ausgabe.sv | 163 ++++++++++++++++
 tb/tb_gwa_ausgabe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gwa_ausgabe.sv
// Payout/dispense controller: queues drink and coin-return commands per type and
// serves them one at a time through pulse / wait-for-ack / cool-down phases.
module gwa_ausgabe #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2,
  parameter int TO_LEN    = 16,
  parameter int CNT_W     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic c10i,
  input  logic c20i,
  input  logic eu1i,
  input  logic eu2i,
  input  logic ack,
  input  logic clr_err,
  output logic c10_drv,
  output logic c20_drv,
  output logic eu1_drv,
  output logic eu2_drv,
  output logic busy,
  output logic err,
  output logic overflow
);

  localparam int MAX_PG = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int MAXL   = (MAX_PG > TO_LEN) ? MAX_PG : TO_LEN;
  localparam int TW     = $clog2(MAXL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT_ACK, GAP, ERR} state_t;

  state_t           r_state;
  logic [TW-1:0]    r_tmr;
  logic [3:0]       r_drv;
  logic             r_busy;
  logic             r_err;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt [4];

  // Index order doubles as service priority: eu1, eu2, c10, c20.
  logic [3:0] w_req;
  logic [3:0] w_pend;
  logic [3:0] w_sat;
  logic [3:0] w_dec;
  logic [1:0] w_pick;
  logic       w_any;
  logic       w_ovf_hit;

  assign w_req = {c20i, c10i, eu2i, eu1i};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_pend[i] = (r_cnt[i] != '0);
      w_sat[i]  = (r_cnt[i] == CNT_MAX);
    end
  end

  always_comb begin
    w_pick = 2'd0;
    if      (w_pend[0]) w_pick = 2'd0;
    else if (w_pend[1]) w_pick = 2'd1;
    else if (w_pend[2]) w_pick = 2'd2;
    else if (w_pend[3]) w_pick = 2'd3;
  end

  assign w_any     = |w_pend;
  assign w_dec     = (r_state == IDLE && w_any && !r_err) ? (4'b0001 << w_pick) : 4'b0000;
  // A request that meets a same-cycle decrement is absorbed, so it never overflows.
  assign w_ovf_hit = |(w_req & w_sat & ~w_dec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_req[i] && !w_dec[i] && !w_sat[i])
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (w_dec[i] && !w_req[i])
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_ovf <= 1'b0;
    else if (w_ovf_hit)
      r_ovf <= 1'b1;
    else if (clr_err)
      r_ovf <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_tmr   <= '0;
      r_drv   <= 4'b0000;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any && !r_err) begin
            r_drv   <= 4'b0001 << w_pick;
            r_tmr   <= '0;
            r_busy  <= 1'b1;
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          if (r_tmr == TW'(PULSE_LEN - 1)) begin
            r_drv   <= 4'b0000;
            r_tmr   <= '0;
            r_state <= WAIT_ACK;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            r_tmr   <= '0;
            r_state <= GAP;
          end else if (r_tmr == TW'(TO_LEN - 1)) begin
            r_err   <= 1'b1;
            r_state <= ERR;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        GAP: begin
          if (r_tmr == TW'(GAP_LEN - 1)) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        ERR: begin
          if (clr_err) begin
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_drv   <= 4'b0000;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign eu1_drv  = r_drv[0];
  assign eu2_drv  = r_drv[1];
  assign c10_drv  = r_drv[2];
  assign c20_drv  = r_drv[3];
  assign busy     = r_busy;
  assign err      = r_err;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_gwa_ausgabe.sv
// Directed bench for gwa_ausgabe with default parameters; drive snapshots are
// packed as {eu1, eu2, c10, c20}.
module tb_gwa_ausgabe;

  logic clk, rst;
  logic c10i, c20i, eu1i, eu2i, ack, clr_err;
  logic c10_drv, c20_drv, eu1_drv, eu2_drv, busy, err, overflow;

  gwa_ausgabe dut (
    .clk(clk), .rst(rst),
    .c10i(c10i), .c20i(c20i), .eu1i(eu1i), .eu2i(eu2i),
    .ack(ack), .clr_err(clr_err),
    .c10_drv(c10_drv), .c20_drv(c20_drv), .eu1_drv(eu1_drv), .eu2_drv(eu2_drv),
    .busy(busy), .err(err), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] P_EU1 = 4'b1000;
  localparam logic [3:0] P_EU2 = 4'b0100;
  localparam logic [3:0] P_C10 = 4'b0010;
  localparam logic [3:0] P_C20 = 4'b0001;
  localparam logic [3:0] P_NONE = 4'b0000;

  int n_chk  = 0;
  int n_pass = 0;
  int n_multi = 0;
  logic [3:0] d [64];
  logic       b [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Capture n cycles of drive/busy; request pulses drop after the first edge.
  task automatic cap(input int n, input int ack_on);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      c10i = 1'b0; c20i = 1'b0; eu1i = 1'b0; eu2i = 1'b0; clr_err = 1'b0;
      d[i] = {eu1_drv, eu2_drv, c10_drv, c20_drv};
      b[i] = busy;
      if ($countones(d[i]) > 1) n_multi++;
      if (i == ack_on) ack = 1'b1;
    end
  endtask

  function automatic int cnt_pat(input logic [3:0] p, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (d[i] === p) c++;
    return c;
  endfunction

  function automatic int first_pat(input logic [3:0] p, input int n);
    for (int i = 0; i < n; i++) if (d[i] === p) return i;
    return -1;
  endfunction

  function automatic int rises(input logic [3:0] p, input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      if (d[i] === p && (i == 0 || d[i-1] !== p)) c++;
    return c;
  endfunction

  initial begin
    rst = 1'b0; c10i = 1'b0; c20i = 1'b0; eu1i = 1'b0; eu2i = 1'b0;
    ack = 1'b0; clr_err = 1'b0;
    step(2);
    chk("reset_drv", {28'd0, eu1_drv, eu2_drv, c10_drv, c20_drv}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b1;
    step(2);

    // Single drink: drive E1..E4, ack from first WAIT cycle, idle at E8
    c10i = 1'b1;
    cap(10, 5);
    ack = 1'b0;
    chk("single_idle_E0", {28'd0, d[0]}, 32'd0);
    chk("single_first", first_pat(P_C10, 10), 1);
    chk("single_len", cnt_pat(P_C10, 10), 4);
    chk("single_fall", {28'd0, d[5]}, 32'd0);
    chk("single_busy_gap", {31'd0, b[7]}, 32'd1);
    chk("single_busy_end", {31'd0, b[8]}, 32'd0);

    // Simultaneous c20 + eu1 with ack held high (also early-ack case)
    ack = 1'b1;
    c20i = 1'b1; eu1i = 1'b1;
    cap(20, -1);
    ack = 1'b0;
    chk("simul_eu1_first", first_pat(P_EU1, 20), 1);
    chk("simul_eu1_len", cnt_pat(P_EU1, 20), 4);
    chk("simul_c20_first", first_pat(P_C20, 20), 9);
    chk("simul_c20_len", cnt_pat(P_C20, 20), 4);
    chk("simul_busy_gap", {31'd0, b[15]}, 32'd1);
    chk("simul_busy_end", {31'd0, b[16]}, 32'd0);

    // Saturation: four eu2 requests while c10 is being driven
    c10i = 1'b1;
    step(1);
    c10i = 1'b0; eu2i = 1'b1;
    step(4);
    eu2i = 1'b0;
    chk("sat_ovf_set", {31'd0, overflow}, 32'd1);
    ack = 1'b1;
    cap(40, -1);
    ack = 1'b0;
    chk("sat_eu2_pulses", rises(P_EU2, 40), 3);
    chk("sat_eu2_cycles", cnt_pat(P_EU2, 40), 12);
    chk("sat_busy_end", {31'd0, b[39]}, 32'd0);
    chk("sat_ovf_sticky", {31'd0, overflow}, 32'd1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("sat_ovf_clr", {31'd0, overflow}, 32'd0);

    // Ack timeout with a c10 queued behind eu1
    eu1i = 1'b1;
    step(1);
    eu1i = 1'b0; c10i = 1'b1;
    step(1);
    c10i = 1'b0;
    chk("to_eu1_drive", {31'd0, eu1_drv}, 32'd1);
    step(19);
    chk("to_err_before", {31'd0, err}, 32'd0);
    step(1);
    chk("to_err_set", {31'd0, err}, 32'd1);
    cap(10, -1);
    chk("to_no_drive", cnt_pat(P_NONE, 10), 10);
    chk("to_busy_err", {31'd0, b[9]}, 32'd1);
    chk("to_err_hold", {31'd0, err}, 32'd1);
    clr_err = 1'b1; ack = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("to_err_clr", {31'd0, err}, 32'd0);
    chk("to_busy_clr", {31'd0, busy}, 32'd0);
    cap(12, -1);
    ack = 1'b0;
    chk("to_c10_first", first_pat(P_C10, 12), 0);
    chk("to_c10_len", cnt_pat(P_C10, 12), 4);
    chk("to_no_eu1", cnt_pat(P_EU1, 12), 0);
    chk("to_busy_end", {31'd0, b[7]}, 32'd0);

    // Asynchronous reset mid-DRIVE with two eu2 pending
    eu1i = 1'b1;
    step(1);
    eu1i = 1'b0; eu2i = 1'b1;
    step(2);
    eu2i = 1'b0;
    chk("rst_pre_drive", {31'd0, eu1_drv}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_drv", {28'd0, eu1_drv, eu2_drv, c10_drv, c20_drv}, 32'd0);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    step(1);
    rst = 1'b1;
    cap(12, -1);
    chk("rst_no_drive", cnt_pat(P_NONE, 12), 12);
    chk("rst_busy_idle", {31'd0, b[11]}, 32'd0);

    chk("onehot_drv", n_multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
